// File: rtl/nibble_serial_adder.sv
// Purpose: multi-cycle WIDTH-bit adder, one 4-bit carry-select nibble per cycle, LSB nibble first.
// Latency: out_valid rises NIBBLES edges after the accepting edge; one operation per NIBBLES+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Option macro: NIBBLE_SERIAL_ADDER_SUB_EN adds a sub port.

// 4-bit carry-select slice: low 2 bits ripple, high 2 bits are precomputed for
// both carry values and picked by the low-half carry.
module nibble_csel_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       c3,
   output logic       co
);

   logic [2:0] lo;
   logic [2:0] hi0;
   logic [2:0] hi1;

   // Both upper-half candidates, selected by the lower-half carry.
   always_comb begin
      lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, ci};
      hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
      hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
      if (lo[2]) begin
         s  = {hi1[1:0], lo[1:0]};
         co = hi1[2];
      end else begin
         s  = {hi0[1:0], lo[1:0]};
         co = hi0[2];
      end
      // Carry into bit 3 recovered from the sum bit; feeds signed overflow.
      c3 = s[3] ^ a[3] ^ b[3];
   end

endmodule

module nibble_serial_adder #(
   parameter int WIDTH = 16   // multiple of 4, at least 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [IDX_W-1:0] idx_q;
   logic [WIDTH-1:0] sum_q;
   logic             c_out_q;
   logic             ovf_q;
   logic             in_ready_q;
   logic             out_valid_q;

   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [3:0]       nib_sum;
   logic             nib_c3;
   logic             nib_co;

   logic [WIDTH-1:0] b_load;
   logic             carry_load;

   // Subtraction is a + ~b + 1; add-only builds pass b and c_in straight through.
   always_comb begin
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      b_load     = sub ? ~b : b;
      carry_load = sub ? 1'b1 : c_in;
`else
      b_load     = b;
      carry_load = c_in;
`endif
   end

   // Pick the operand nibbles addressed by the current index.
   always_comb begin
      a_nib = 4'h0;
      b_nib = 4'h0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_nib = a_q[4*i +: 4];
            b_nib = b_q[4*i +: 4];
         end
      end
   end

   nibble_csel_slice u_slice (
      .a  (a_nib),
      .b  (b_nib),
      .ci (carry_q),
      .s  (nib_sum),
      .c3 (nib_c3),
      .co (nib_co)
   );

   // Sequencing FSM: accept in IDLE, one nibble per edge in RUN, hold result in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         sum_q       <= '0;
         c_out_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b_load;
                  carry_q    <= carry_load;
                  idx_q      <= '0;
                  sum_q      <= '0;
                  in_ready_q <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < NIBBLES; i++) begin
                  if (idx_q == IDX_W'(i)) begin
                     sum_q[4*i +: 4] <= nib_sum;
                  end
               end
               carry_q <= nib_co;
               // The index stops on the last nibble rather than wrapping.
               if (idx_q == LAST_IDX) begin
                  c_out_q     <= nib_co;
                  ovf_q       <= nib_c3 ^ nib_co;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign c_out     = c_out_q;
   assign overflow  = ovf_q;

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle wide adder that wraps the team's 4-bit carry-select slice datapath. It accepts WIDTH-bit operands over a valid/ready handshake and feeds one nibble per cycle, least significant first, through an internal 4-bit carry-select stage. It registers each nibble sum and the inter-nibble carry, then presents the full sum downstream with its own valid/ready handshake. It is the sequencing stage for wide additions where a single-cycle WIDTH-bit carry chain is too slow.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and >= 4
NIBBLES, WIDTH/4, derived; number of slice iterations; not overridable

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operands and c_in are valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry into bit 0
out_valid  output  1  result is valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  registered sum
c_out  output  1  carry out of bit WIDTH-1
overflow  output  1  signed overflow: carry into bit WIDTH-1 XOR c_out

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: in_ready=1 (state IDLE), out_valid=0, sum=0, c_out=0, overflow=0. Nibble index=0, carry register=0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a, b and c_in; carry<=c_in; idx<=0; sum<=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge: compute nibble idx as a[4i+3:4i] + b[4i+3:4i] + carry.
  - Nibble datapath is carry-select: the upper 2 bits are computed for carry 0 and carry 1, then selected by the lower-2-bit carry.
  - The nibble result is written into sum[4i+3:4i], carry <= nibble carry-out, idx <= idx+1.
  - When idx == NIBBLES-1: c_out <= nibble carry-out, overflow <= carry into bit 3 of that nibble XOR nibble carry-out, then go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, c_out and overflow are held stable until an edge with out_ready=1, then go to IDLE.
- Latency: out_valid goes high exactly NIBBLES edges after the accepting edge (4 for WIDTH=16; 1 for WIDTH=4).
- Throughput: one operation per NIBBLES+2 cycles. There is no back-to-back acceptance; in_ready is high only in IDLE.
- in_valid in RUN or DONE is ignored. Operands are not re-sampled mid-operation.
- out_ready outside DONE has no effect.
- Arithmetic is modulo 2^WIDTH, with the carry reported on c_out. The result must equal a+b+c_in bit-exactly for all inputs.
- rst wins over all other events in any state, including mid-RUN and DONE with out_ready=1. The next cycle shows reset values; a partial result is discarded.
- The nibble index never wraps: RUN exits on the last nibble. The index width is clog2(NIBBLES), minimum 1.

Optional Feature:
Macro NIBBLE_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds port "sub  input  1", sampled with the operands on accept.
  - sub=1 latches ~b and forces the initial carry to 1, ignoring c_in, so sum = a-b mod 2^WIDTH. c_out=1 means no borrow; overflow is signed subtraction overflow.
  - sub=0 behaves exactly as the base block.
- Not defined: no sub port; add only.

Test Plan:
1. WIDTH=16, a=16'h00FF, b=16'h0001, c_in=0 accepted at edge T -> out_valid rises after edge T+4; sum=16'h0100, c_out=0, overflow=0.
2. a=16'hFFFF, b=16'h0000, c_in=1 -> sum=16'h0000, c_out=1, overflow=0. The carry ripples through all 4 nibble iterations.
3. a=16'h7FFF, b=16'h0001, c_in=0 -> sum=16'h8000, c_out=0, overflow=1. Also a=16'h8000, b=16'h8000 -> sum=16'h0000, c_out=1, overflow=1.
4. Backpressure: result from case 1 with out_ready=0 for 5 cycles while in_valid=1 and new operands toggle -> in_ready=0, and sum/c_out/overflow are unchanged. out_ready=1 -> IDLE next cycle; the held in_valid is then accepted.
5. rst=1 for one edge while in RUN at idx=2 -> next cycle: IDLE, in_ready=1, out_valid=0, sum=0. A fresh operation a=16'h1234, b=16'h1111 then yields sum=16'h2345.
6. With NIBBLE_SERIAL_ADDER_SUB_EN: a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, c_out=0, overflow=0. a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, c_out=1, overflow=1.
